// File: rtl/led_panel_pkg.sv
// Shared scan-path definitions: FSM encoding, panel geometry defaults
// and width helpers used by the scan master and its BCM show timer.
package led_panel_pkg;

  localparam int DEF_ROWS_LINES = 4;
  localparam int DEF_COLS_LINES = 6;
  localparam int DEF_COLOR_BITS = 8;
  localparam int DEF_BASE_TIME  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_BLANK = 3'd2,
    ST_LATCH = 3'd3,
    ST_SHOW  = 3'd4
  } scan_state_e;

  // Bitplane index width; never below one bit.
  function automatic int bp_w(input int bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

  // Show counter width, holds BASE_TIME << (COLOR_BITS-1).
  function automatic int show_w(input int base, input int bits);
    return $clog2(base) + bits;
  endfunction

endpackage

// File: rtl/led_scan_bcm_timer.sv
// BCM show timer: load BASE_TIME<<plane, count down, pulse done on last clock.
// Ports: clock, reset (async high), load_i, plane_i, done_o.
module led_scan_bcm_timer
  import led_panel_pkg::*;
#(
  parameter int BASE_TIME  = DEF_BASE_TIME,
  parameter int COLOR_BITS = DEF_COLOR_BITS,
  localparam int BP_W = bp_w(COLOR_BITS),
  localparam int CW   = show_w(BASE_TIME, COLOR_BITS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_i,
  input  logic [BP_W-1:0] plane_i,
  output logic            done_o
);

  localparam logic [CW-1:0] BASE = CW'(BASE_TIME);

  logic [CW-1:0] cnt_q;
  logic          run_q;

  // Loaded with N-1 so done_o is high in the Nth clock after load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load_i) begin
      cnt_q <= (BASE << plane_i) - CW'(1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/led_panel_scan_master.sv
// HUB75 scan master: per row/bitplane shift, blank, latch, then BCM show.
// Ports: clock, reset, enable, swap_req -> swap_ack, frame_start,
//   memAddrMst, bitplaneMst, backbufferMst, ADDR/LATCH/CLK_LED/BLANK_MST.
// LEDSCAN_FRAME_COUNT_EN adds frame_count[15:0] (+1 per frame_start).
module led_panel_scan_master
  import led_panel_pkg::*;
#(
  parameter int DISPLAY_ROWS_LINES = DEF_ROWS_LINES,
  parameter int DISPLAY_COLS_LINES = DEF_COLS_LINES,
  parameter int COLOR_BITS         = DEF_COLOR_BITS,
  parameter int BASE_TIME          = DEF_BASE_TIME,
  localparam int R    = DISPLAY_ROWS_LINES,
  localparam int C    = DISPLAY_COLS_LINES,
  localparam int BP_W = bp_w(COLOR_BITS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            swap_req,
  output logic            swap_ack,
  output logic            frame_start,
  output logic [R+C-1:0]  memAddrMst,
  output logic [BP_W-1:0] bitplaneMst,
  output logic            backbufferMst,
  output logic [R-1:0]    ADDR_MST,
  output logic            LATCH_MST,
  output logic            CLK_LED_MST,
  output logic            BLANK_MST
`ifdef LEDSCAN_FRAME_COUNT_EN
  ,
  output logic [15:0]     frame_count
`endif
);

  localparam logic [BP_W-1:0] PLANE_LAST = BP_W'(COLOR_BITS - 1);
  localparam logic [R-1:0]    ROW_LAST   = '1;
  localparam logic [C-1:0]    COL_LAST   = '1;

  scan_state_e     state_q;
  logic [R-1:0]    row_q;
  logic [C-1:0]    col_q;
  logic [BP_W-1:0] plane_q;
  logic            ph_q;
  logic [R-1:0]    addr_q;
  logic            latch_q;
  logic            clk_q;
  logic            blank_q;
  logic            bb_q;
  logic            ack_q;
  logic            fs_q;
  logic            show_load;
  logic            show_done;

  assign show_load = (state_q == ST_LATCH);

  led_scan_bcm_timer #(
    .BASE_TIME  (BASE_TIME),
    .COLOR_BITS (COLOR_BITS)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load_i  (show_load),
    .plane_i (plane_q),
    .done_o  (show_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      plane_q <= '0;
      ph_q    <= 1'b0;
      addr_q  <= '0;
      latch_q <= 1'b0;
      clk_q   <= 1'b0;
      blank_q <= 1'b1;
      bb_q    <= 1'b0;
      ack_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      fs_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          blank_q <= 1'b1;
          if (enable) begin
            state_q <= ST_SHIFT;
            fs_q    <= 1'b1;
            if (swap_req) begin
              bb_q  <= ~bb_q;
              ack_q <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (!ph_q) begin
            ph_q  <= 1'b1;
            clk_q <= 1'b1;
          end else begin
            ph_q  <= 1'b0;
            clk_q <= 1'b0;
            col_q <= col_q + C'(1);
            if (col_q == COL_LAST) begin
              state_q <= ST_BLANK;
              addr_q  <= row_q;
            end
          end
        end
        ST_BLANK: begin
          latch_q <= 1'b1;
          state_q <= ST_LATCH;
        end
        ST_LATCH: begin
          latch_q <= 1'b0;
          blank_q <= 1'b0;
          state_q <= ST_SHOW;
        end
        ST_SHOW: begin
          if (show_done) begin
            blank_q <= 1'b1;
            if (!enable) begin
              // Stopping discards position; resume starts a new frame.
              state_q <= ST_IDLE;
              row_q   <= '0;
              col_q   <= '0;
              plane_q <= '0;
            end else begin
              state_q <= ST_SHIFT;
              if (plane_q != PLANE_LAST) begin
                plane_q <= plane_q + BP_W'(1);
              end else begin
                plane_q <= '0;
                row_q   <= row_q + R'(1);
                if (row_q == ROW_LAST) begin
                  fs_q <= 1'b1;
                  if (swap_req) begin
                    bb_q  <= ~bb_q;
                    ack_q <= 1'b1;
                  end
                end
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign swap_ack      = ack_q;
  assign frame_start   = fs_q;
  assign memAddrMst    = {row_q, col_q};
  assign bitplaneMst   = plane_q;
  assign backbufferMst = bb_q;
  assign ADDR_MST      = addr_q;
  assign LATCH_MST     = latch_q;
  assign CLK_LED_MST   = clk_q;
  assign BLANK_MST     = blank_q;

`ifdef LEDSCAN_FRAME_COUNT_EN
  logic [15:0] fc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     fc_q <= '0;
    else if (fs_q) fc_q <= fc_q + 16'd1;
  end

  assign frame_count = fc_q;
`endif

endmodule

// File: tb/tb_led_panel_scan_master.sv
// Bench for led_panel_scan_master: plane-by-plane observation compared
// against geometry/timing expectations computed from the scan rules.
module tb_led_panel_scan_master;

  localparam int R     = 4;
  localparam int C     = 6;
  localparam int CB    = 8;
  localparam int BT    = 8;
  localparam int NROW  = 16;
  localparam int NCOL  = 64;
  localparam int RW    = R + C;
  localparam int LIMIT = 4000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic swap_req = 1'b0;
  logic swap_ack, frame_start, backbufferMst;
  logic [RW-1:0] memAddrMst;
  logic [2:0] bitplaneMst;
  logic [R-1:0] ADDR_MST;
  logic LATCH_MST, CLK_LED_MST, BLANK_MST;
`ifdef LEDSCAN_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  led_panel_scan_master #(
    .DISPLAY_ROWS_LINES (R),
    .DISPLAY_COLS_LINES (C),
    .COLOR_BITS         (CB),
    .BASE_TIME          (BT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .swap_req      (swap_req),
    .swap_ack      (swap_ack),
    .frame_start   (frame_start),
    .memAddrMst    (memAddrMst),
    .bitplaneMst   (bitplaneMst),
    .backbufferMst (backbufferMst),
    .ADDR_MST      (ADDR_MST),
    .LATCH_MST     (LATCH_MST),
    .CLK_LED_MST   (CLK_LED_MST),
    .BLANK_MST     (BLANK_MST)
`ifdef LEDSCAN_FRAME_COUNT_EN
    ,
    .frame_count   (frame_count)
`endif
  );

  always #10 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Observations of one plane, filled by run_plane.
  int pulses, overlap, latches, lows, fs_n, ack_n;
  int latch_idx, last_clk_idx, low_first, cycles;
  bit timeout;
  logic [R-1:0] latch_addr;
  logic [2:0] plane_seen;
  logic bb_first;
  logic [RW-1:0] first_addr;
  logic [RW-1:0] addr_seen[$];
  int bb_m = 0;

  // Observe from the current cycle (first of a plane) until BLANK_MST
  // returns high after the show window; optionally drop enable at a cycle.
  task automatic run_plane(input int drop_at);
    bit low_seen;
    low_seen = 0;
    pulses = 0; overlap = 0; latches = 0; lows = 0; fs_n = 0; ack_n = 0;
    latch_idx = -1; last_clk_idx = -1; low_first = -1; cycles = 0;
    timeout = 0; latch_addr = '0;
    addr_seen.delete();
    plane_seen = bitplaneMst;
    bb_first = backbufferMst;
    first_addr = memAddrMst;
    while (!(low_seen && BLANK_MST) && cycles < LIMIT) begin
      if (CLK_LED_MST) begin
        pulses++;
        last_clk_idx = cycles;
        addr_seen.push_back(memAddrMst);
        if (!BLANK_MST) overlap++;
      end
      if (LATCH_MST) begin
        latches++;
        latch_idx = cycles;
        latch_addr = ADDR_MST;
      end
      if (!BLANK_MST) begin
        lows++;
        low_seen = 1;
        if (low_first < 0) low_first = cycles;
      end
      if (frame_start) fs_n++;
      if (swap_ack) ack_n++;
      if (cycles == drop_at) enable = 1'b0;
      cycles++;
      @(negedge clock);
    end
    if (cycles >= LIMIT) timeout = 1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++; if (BLANK_MST !== 1'b1) begin bad++; $display("FAIL rst_blank: got %b want 1", BLANK_MST); end
    total++; if (LATCH_MST !== 1'b0 || CLK_LED_MST !== 1'b0) begin bad++; $display("FAIL rst_strobes: latch=%b clk=%b want 0", LATCH_MST, CLK_LED_MST); end
    total++; if (memAddrMst !== '0) begin bad++; $display("FAIL rst_addr: got %0d want 0", memAddrMst); end
    total++; if (bitplaneMst !== '0 || backbufferMst !== 1'b0) begin bad++; $display("FAIL rst_plane_bb: plane=%0d bb=%b want 0", bitplaneMst, backbufferMst); end
    total++; if (ADDR_MST !== '0 || swap_ack !== 1'b0 || frame_start !== 1'b0) begin bad++; $display("FAIL rst_misc: addr=%0d ack=%b fs=%b want 0", ADDR_MST, swap_ack, frame_start); end
`ifdef LEDSCAN_FRAME_COUNT_EN
    total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL rst_fc: got %0d want 0", frame_count); end
`endif
    reset = 1'b0;
    repeat (4) @(negedge clock);
    total++; if (BLANK_MST !== 1'b1 || CLK_LED_MST !== 1'b0) begin bad++; $display("FAIL idle_hold: blank=%b clk=%b want 1/0", BLANK_MST, CLK_LED_MST); end
  endtask

  task automatic test_first_plane();
    int addr_bad;
    enable = 1'b1;
    @(negedge clock);
    run_plane(-1);
    addr_bad = 0;
    foreach (addr_seen[i]) if (addr_seen[i] !== RW'(i)) addr_bad++;
    total++; if (timeout) begin bad++; $display("FAIL p0_timeout: got %0d cycles want %0d", cycles, 2*NCOL+2+BT); end
    total++; if (pulses !== NCOL) begin bad++; $display("FAIL p0_pulses: got %0d want %0d", pulses, NCOL); end
    total++; if (addr_bad !== 0) begin bad++; $display("FAIL p0_addrseq: got %0d wrong want 0", addr_bad); end
    total++; if (last_clk_idx !== 2*NCOL-1) begin bad++; $display("FAIL p0_lastclk: got %0d want %0d", last_clk_idx, 2*NCOL-1); end
    total++; if (latches !== 1 || latch_idx !== 2*NCOL+1) begin bad++; $display("FAIL p0_latch: got n=%0d at %0d want 1 at %0d", latches, latch_idx, 2*NCOL+1); end
    total++; if (latch_addr !== '0) begin bad++; $display("FAIL p0_latchaddr: got %0d want 0", latch_addr); end
    total++; if (lows !== BT || low_first !== 2*NCOL+2) begin bad++; $display("FAIL p0_show: got %0d at %0d want %0d at %0d", lows, low_first, BT, 2*NCOL+2); end
    total++; if (cycles !== 2*NCOL+2+BT) begin bad++; $display("FAIL p0_cycles: got %0d want %0d", cycles, 2*NCOL+2+BT); end
    total++; if (fs_n !== 1 || ack_n !== 0) begin bad++; $display("FAIL p0_pulse: fs=%0d ack=%0d want 1/0", fs_n, ack_n); end
    total++; if (overlap !== 0 || plane_seen !== 3'd0) begin bad++; $display("FAIL p0_misc: overlap=%0d plane=%0d want 0/0", overlap, plane_seen); end
    total++; if (bitplaneMst !== 3'd1) begin bad++; $display("FAIL p0_next_plane: got %0d want 1", bitplaneMst); end
  endtask

  // Rest of the first frame with random swap_req levels that only matter
  // at the frame boundary; the last plane holds swap_req high.
  task automatic test_full_frame();
    for (int k = 1; k < NROW*CB; k++) begin
      int row, pl, exp_low, addr_bad;
      row = k / CB;
      pl = k % CB;
      exp_low = BT << pl;
      swap_req = (k == NROW*CB-1) ? 1'b1 : 1'($urandom_range(0, 1));
      run_plane(-1);
      addr_bad = 0;
      foreach (addr_seen[i]) if (addr_seen[i] !== RW'(row*NCOL + i)) addr_bad++;
      total++; if (timeout) begin bad++; $display("FAIL k%0d_timeout: got %0d cycles want %0d", k, cycles, 2*NCOL+2+exp_low); end
      total++; if (pulses !== NCOL || addr_bad !== 0) begin bad++; $display("FAIL k%0d_shift: got %0d pulses %0d bad addr want %0d/0", k, pulses, addr_bad, NCOL); end
      total++; if (plane_seen !== 3'(pl)) begin bad++; $display("FAIL k%0d_plane: got %0d want %0d", k, plane_seen, pl); end
      total++; if (latch_addr !== R'(row) || latch_idx !== 2*NCOL+1) begin bad++; $display("FAIL k%0d_latch: got addr %0d at %0d want %0d at %0d", k, latch_addr, latch_idx, row, 2*NCOL+1); end
      total++; if (lows !== exp_low || cycles !== 2*NCOL+2+exp_low) begin bad++; $display("FAIL k%0d_show: got %0d low %0d cyc want %0d/%0d", k, lows, cycles, exp_low, 2*NCOL+2+exp_low); end
      total++; if (fs_n !== 0 || ack_n !== 0 || bb_first !== 1'(bb_m)) begin bad++; $display("FAIL k%0d_frame: fs=%0d ack=%0d bb=%b want 0/0/%0d", k, fs_n, ack_n, bb_first, bb_m); end
      total++; if (overlap !== 0 || latches !== 1) begin bad++; $display("FAIL k%0d_overlap: ov=%0d latches=%0d want 0/1", k, overlap, latches); end
    end
  endtask

  task automatic test_swap();
    run_plane(-1);
    bb_m ^= 1;
    total++; if (fs_n !== 1 || ack_n !== 1) begin bad++; $display("FAIL wrap_pulses: fs=%0d ack=%0d want 1/1", fs_n, ack_n); end
    total++; if (bb_first !== 1'(bb_m)) begin bad++; $display("FAIL wrap_bb: got %b want %0d", bb_first, bb_m); end
    total++; if (first_addr !== '0 || plane_seen !== 3'd0) begin bad++; $display("FAIL wrap_addr: addr=%0d plane=%0d want 0/0", first_addr, plane_seen); end
    total++; if (latch_addr !== '0 || lows !== BT) begin bad++; $display("FAIL wrap_plane: latch=%0d low=%0d want 0/%0d", latch_addr, lows, BT); end
  endtask

  task automatic test_enable_drop();
    int viol;
    run_plane(40);
    total++; if (ack_n !== 0 || bb_first !== 1'(bb_m)) begin bad++; $display("FAIL held_swap: ack=%0d bb=%b want 0/%0d", ack_n, bb_first, bb_m); end
    total++; if (pulses !== NCOL || latches !== 1 || lows !== (BT << 1)) begin bad++; $display("FAIL drop_finish: got %0d/%0d/%0d want %0d/1/%0d", pulses, latches, lows, NCOL, BT << 1); end
    viol = 0;
    for (int i = 0; i < 12; i++) begin
      if (BLANK_MST !== 1'b1 || CLK_LED_MST !== 1'b0 || LATCH_MST !== 1'b0) viol++;
      @(negedge clock);
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL drop_idle: got %0d active cycles want 0", viol); end
    swap_req = 1'b0;
    enable = 1'b1;
    @(negedge clock);
    total++; if (frame_start !== 1'b1 || swap_ack !== 1'b0) begin bad++; $display("FAIL resume_pulse: fs=%b ack=%b want 1/0", frame_start, swap_ack); end
    total++; if (memAddrMst !== '0 || bitplaneMst !== '0 || backbufferMst !== 1'(bb_m)) begin bad++; $display("FAIL resume_pos: addr=%0d plane=%0d bb=%b want 0/0/%0d", memAddrMst, bitplaneMst, backbufferMst, bb_m); end
  endtask

  task automatic test_reset_mid_show();
    int w;
    w = 0;
    while (BLANK_MST && w < 300) begin
      @(negedge clock);
      w++;
    end
    total++; if (BLANK_MST !== 1'b0) begin bad++; $display("FAIL show_reach: blank=%b after %0d want 0", BLANK_MST, w); end
    repeat (3) @(negedge clock);
    #5 reset = 1'b1;
    #1;
    bb_m = 0;
    total++; if (BLANK_MST !== 1'b1 || CLK_LED_MST !== 1'b0 || LATCH_MST !== 1'b0) begin bad++; $display("FAIL arst_strobes: blank=%b clk=%b latch=%b want 1/0/0", BLANK_MST, CLK_LED_MST, LATCH_MST); end
    total++; if (backbufferMst !== 1'b0 || memAddrMst !== '0 || bitplaneMst !== '0) begin bad++; $display("FAIL arst_state: bb=%b addr=%0d plane=%0d want 0", backbufferMst, memAddrMst, bitplaneMst); end
`ifdef LEDSCAN_FRAME_COUNT_EN
    total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL arst_fc: got %0d want 0", frame_count); end
`endif
    repeat (3) @(negedge clock);
    total++; if (BLANK_MST !== 1'b1 || CLK_LED_MST !== 1'b0) begin bad++; $display("FAIL arst_hold: blank=%b clk=%b want 1/0", BLANK_MST, CLK_LED_MST); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Two resumes from idle: each is a frame boundary.
  task automatic test_resume();
    for (int n = 1; n <= 2; n++) begin
      run_plane(0);
      total++; if (fs_n !== 1 || pulses !== NCOL || lows !== BT) begin bad++; $display("FAIL resume%0d: fs=%0d pulses=%0d low=%0d want 1/%0d/%0d", n, fs_n, pulses, lows, NCOL, BT); end
`ifdef LEDSCAN_FRAME_COUNT_EN
      total++; if (frame_count !== 16'(n)) begin bad++; $display("FAIL fc%0d: got %0d want %0d", n, frame_count, n); end
`endif
      enable = 1'b1;
      @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_first_plane();
    test_full_frame();
    test_swap();
    test_enable_drop();
    test_reset_mid_show();
    test_resume();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
